ex_cond_stage: RTL

//  Decode-to-execute pipeline register plus ARM conditional-execution unit.

---
 rtl/ex_cond_stage_if.sv | 78 +++++++
 rtl/ex_cond_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_cond_stage_if.sv
// Bundle of the decode-side, execute-side and hazard-control signals of ex_cond_stage.
// Latency: none (wires only). The producer/consumer modport drives the D fields, StallE/FlushE and ALUFlagsE.
// Backpressure: StallE holds the E slot and FlushE inserts a bubble. SquashCnt exists only with COND_SQUASH_CNT_EN.
interface ex_cond_stage_if #(
    parameter int DATA_WIDTH = 32
`ifdef COND_SQUASH_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
);
    // hazard control
    logic                  StallE;
    logic                  FlushE;

    // decode-stage controls and operands
    logic                  PCSrcD;
    logic                  RegWriteD;
    logic                  MemWriteD;
    logic                  MemtoRegD;
    logic                  ALUSrcD;
    logic                  BranchD;
    logic [2:0]            ALUControlD;
    logic [1:0]            FlagWriteD;
    logic [1:0]            ImmSrcD;
    logic [3:0]            CondD;
    logic [DATA_WIDTH-1:0] RD1D;
    logic [DATA_WIDTH-1:0] RD2D;
    logic [DATA_WIDTH-1:0] ExtImmD;
    logic [3:0]            WA3D;

    // ALU result flags of the instruction currently in E
    logic [3:0]            ALUFlagsE;

    // execute-stage registered outputs
    logic                  MemtoRegE;
    logic                  ALUSrcE;
    logic [2:0]            ALUControlE;
    logic [1:0]            ImmSrcE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ExtImmE;
    logic [3:0]            WA3E;
    logic                  ValidE;
    logic                  CondExE;
    logic                  PCSrcGE;
    logic                  RegWriteGE;
    logic                  MemWriteGE;
    logic                  BranchTakenE;
    logic [3:0]            FlagsQ;
`ifdef COND_SQUASH_CNT_EN
    logic [CNT_WIDTH-1:0]  SquashCnt;
`endif

    modport master (
        output StallE, FlushE,
        output PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD,
        output ALUControlD, FlagWriteD, ImmSrcD, CondD,
        output RD1D, RD2D, ExtImmD, WA3D, ALUFlagsE,
        input  MemtoRegE, ALUSrcE, ALUControlE, ImmSrcE,
        input  RD1E, RD2E, ExtImmE, WA3E,
        input  ValidE, CondExE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE, FlagsQ
`ifdef COND_SQUASH_CNT_EN
        , input SquashCnt
`endif
    );

    modport slave (
        input  StallE, FlushE,
        input  PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD,
        input  ALUControlD, FlagWriteD, ImmSrcD, CondD,
        input  RD1D, RD2D, ExtImmD, WA3D, ALUFlagsE,
        output MemtoRegE, ALUSrcE, ALUControlE, ImmSrcE,
        output RD1E, RD2E, ExtImmE, WA3E,
        output ValidE, CondExE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE, FlagsQ
`ifdef COND_SQUASH_CNT_EN
        , output SquashCnt
`endif
    );
endinterface

// File: rtl/ex_cond_stage.sv
// Decode-to-execute pipeline register with NZCV flag state and ARM condition evaluation gating EX side effects.
// Latency: D fields appear in E exactly one cycle later; the condition and gated controls are combinational on E regs/FlagsQ.
// Backpressure: StallE freezes the E slot and flag/counter updates; FlushE (wins over StallE) loads a bubble. Optional squash counter: COND_SQUASH_CNT_EN.
module ex_cond_stage #(
    parameter int DATA_WIDTH = 32
`ifdef COND_SQUASH_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_cond_stage_if.slave bus
);

    // ARM condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    // E-stage control registers
    logic                  valid_e;
    logic                  pc_src_e;
    logic                  reg_write_e;
    logic                  mem_write_e;
    logic                  mem_to_reg_e;
    logic                  alu_src_e;
    logic                  branch_e;
    logic [2:0]            alu_control_e;
    logic [1:0]            flag_write_e;
    logic [1:0]            imm_src_e;
    logic [3:0]            cond_e;

    // E-stage datapath registers
    logic [DATA_WIDTH-1:0] rd1_e;
    logic [DATA_WIDTH-1:0] rd2_e;
    logic [DATA_WIDTH-1:0] ext_imm_e;
    logic [3:0]            wa3_e;

    // architectural flags {N,Z,C,V}
    logic [3:0]            flags_q;
    logic                  flag_n;
    logic                  flag_z;
    logic                  flag_c;
    logic                  flag_v;

    logic                  cond_pass;
    logic                  cond_ex;
    logic                  retire;
    logic                  write_nz;
    logic                  write_cv;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition check uses the flags as they stand before the coming edge;
    // 1111 has no defined meaning here and is executed like AL.
    always_comb begin
        cond_pass = 1'b1;
        case (cond_e)
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = !flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = !flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = !flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = !flag_v;
            COND_HI: cond_pass = flag_c && !flag_z;
            COND_LS: cond_pass = !flag_c || flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = !flag_z && (flag_n == flag_v);
            COND_LE: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // An empty slot never executes, whatever its stale condition field says.
    assign cond_ex = valid_e && cond_pass;

    // The E instruction leaves the slot on any non-stalled edge; a flush only
    // replaces what comes in from D, so it does not cancel the leaving instruction.
    assign retire   = valid_e && !bus.StallE;
    assign write_nz = retire && cond_pass && flag_write_e[1];
    assign write_cv = retire && cond_pass && flag_write_e[0];

    // E-slot control registers: reset, then bubble, then hold, then load from D.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_e       <= 1'b0;
            pc_src_e      <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            mem_to_reg_e  <= 1'b0;
            alu_src_e     <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            flag_write_e  <= 2'b00;
            imm_src_e     <= 2'b00;
            cond_e        <= 4'b0000;
        end else if (bus.FlushE) begin
            valid_e       <= 1'b0;
            pc_src_e      <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            mem_to_reg_e  <= 1'b0;
            alu_src_e     <= 1'b0;
            branch_e      <= 1'b0;
            alu_control_e <= 3'b000;
            flag_write_e  <= 2'b00;
            imm_src_e     <= 2'b00;
            cond_e        <= 4'b0000;
        end else if (!bus.StallE) begin
            valid_e       <= 1'b1;
            pc_src_e      <= bus.PCSrcD;
            reg_write_e   <= bus.RegWriteD;
            mem_write_e   <= bus.MemWriteD;
            mem_to_reg_e  <= bus.MemtoRegD;
            alu_src_e     <= bus.ALUSrcD;
            branch_e      <= bus.BranchD;
            alu_control_e <= bus.ALUControlD;
            flag_write_e  <= bus.FlagWriteD;
            imm_src_e     <= bus.ImmSrcD;
            cond_e        <= bus.CondD;
        end
    end

    // E-slot datapath registers; zeroed on a bubble so nothing stale is visible.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.FlushE) begin
            rd1_e     <= '0;
            rd2_e     <= '0;
            ext_imm_e <= '0;
            wa3_e     <= 4'b0000;
        end else if (!bus.StallE) begin
            rd1_e     <= bus.RD1D;
            rd2_e     <= bus.RD2D;
            ext_imm_e <= bus.ExtImmD;
            wa3_e     <= bus.WA3D;
        end
    end

    // Flags are committed by the executing instruction as it leaves E; NZ and CV
    // are updated independently according to its FlagWrite bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            if (write_nz) begin
                flags_q[3:2] <= bus.ALUFlagsE[3:2];
            end
            if (write_cv) begin
                flags_q[1:0] <= bus.ALUFlagsE[1:0];
            end
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [CNT_WIDTH-1:0] squash_cnt;

    // Count real instructions discarded by their condition, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt <= '0;
        end else if (retire && !cond_pass && (squash_cnt != {CNT_WIDTH{1'b1}})) begin
            squash_cnt <= squash_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.SquashCnt = squash_cnt;
`endif

    assign bus.MemtoRegE    = mem_to_reg_e;
    assign bus.ALUSrcE      = alu_src_e;
    assign bus.ALUControlE  = alu_control_e;
    assign bus.ImmSrcE      = imm_src_e;
    assign bus.RD1E         = rd1_e;
    assign bus.RD2E         = rd2_e;
    assign bus.ExtImmE      = ext_imm_e;
    assign bus.WA3E         = wa3_e;
    assign bus.ValidE       = valid_e;
    assign bus.CondExE      = cond_ex;
    assign bus.PCSrcGE      = pc_src_e && cond_ex;
    assign bus.RegWriteGE   = reg_write_e && cond_ex;
    assign bus.MemWriteGE   = mem_write_e && cond_ex;
    assign bus.BranchTakenE = branch_e && cond_ex;
    assign bus.FlagsQ       = flags_q;

endmodule
